fir_mac_engine: RTL and testbench

Time-multiplexed multi-band FIR filter that consumes the coefficient writes decoded by the SPI register block. It holds one shared input delay line and a coefficient bank of FILTERS x TAPS entries. For each accepted audio sample it computes every filter in turn on a single multiply-accumulate unit and emits one result per filter, tagged with the filter index. It sits between the SPI register interface (coefficients) and the audio output path (samples).

---
 rtl/fir_mac_engine.sv | 164 ++++++++++++++++
 tb/tb_fir_mac_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_engine
// Description : Time-multiplexed multi-band FIR filter. One shared delay line,
//               a FILTERS x TAPS coefficient bank and a single MAC unit that
//               evaluates every filter in turn for each accepted sample.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_engine #(
  parameter int TAPS    = 8,
  parameter int FILTERS = 4,
  parameter int DATA_W  = 24,
  parameter int COEF_W  = 16,
  localparam int FW     = (FILTERS > 1) ? $clog2(FILTERS) : 1,
  localparam int TW     = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              coef_wr_stb,
  input  logic [FW-1:0]     coef_filter,
  input  logic [TW-1:0]     coef_tap,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sat_clr,
  output logic              busy,
  output logic              out_valid,
  output logic [FW-1:0]     out_filter,
  output logic [DATA_W-1:0] out_data,
  output logic              overrun,
  output logic              sat_flag
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + TW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0] state, state_nxt;

  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [COEF_W-1:0] coef [FILTERS][TAPS];

  logic [FW-1:0]           f_idx;
  logic [TW-1:0]           t_idx;
  logic signed [ACC_W-1:0] acc;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        sat_val;
  logic                     sat_hit;
  logic                     last_tap;
  logic                     last_filter;

  assign last_tap    = (t_idx == TW'(TAPS - 1));
  assign last_filter = (f_idx == FW'(FILTERS - 1));

  // Full-precision product of the current tap; the register read sees the
  // pre-write coefficient when a write lands on the same entry this cycle.
  assign prod     = x[t_idx] * coef[f_idx][t_idx];
  assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign shifted  = acc_next >>> (COEF_W - 1);

  // Saturate the rescaled sum: in range only if all bits above the sign agree.
  always_comb begin
    sat_hit = !((&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]));
    sat_val = shifted[DATA_W-1:0];
    if (sat_hit) begin
      sat_val = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sample_valid) state_nxt = S_MAC;
      S_MAC:   if (last_tap)     state_nxt = S_OUT;
      S_OUT:   state_nxt = last_filter ? S_IDLE : S_MAC;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Delay line, tap/filter counters and accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      f_idx <= '0;
      t_idx <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            x[0] <= sample_in;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            f_idx <= '0;
            t_idx <= '0;
            acc   <= '0;
          end
        end
        S_MAC: begin
          acc   <= acc_next;
          t_idx <= t_idx + TW'(1);
        end
        S_OUT: begin
          if (!last_filter) f_idx <= f_idx + FW'(1);
          t_idx <= '0;
          acc   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Result registers load on the last MAC tap so they are valid in OUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_filter <= '0;
      out_data   <= '0;
      sat_flag   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample_valid && (state != S_IDLE);
      if (state == S_MAC && last_tap) begin
        out_valid  <= 1'b1;
        out_filter <= f_idx;
        out_data   <= sat_val;
      end
      if (state == S_MAC && last_tap && sat_hit) sat_flag <= 1'b1;
      else if (sat_clr)                          sat_flag <= 1'b0;
    end
  end

  // Coefficient bank; writes are accepted in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int fi = 0; fi < FILTERS; fi++)
        for (int ti = 0; ti < TAPS; ti++)
          coef[fi][ti] <= '0;
    end else if (coef_wr_stb && (32'(coef_filter) < FILTERS)) begin
      coef[coef_filter][coef_tap] <= coef_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fir_mac_engine
// Description : Directed self-checking bench for fir_mac_engine with a
//               reference model feeding an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_engine;
  localparam int TAPS = 8, FILTERS = 4, DATA_W = 24, COEF_W = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              coef_wr_stb;
  logic [1:0]        coef_filter;
  logic [2:0]        coef_tap;
  logic [COEF_W-1:0] coef_data;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              sat_clr;
  logic              busy, out_valid, overrun, sat_flag;
  logic [1:0]        out_filter;
  logic [DATA_W-1:0] out_data;

  fir_mac_engine #(.TAPS(TAPS), .FILTERS(FILTERS), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
    .clk(clk), .reset_n(reset_n), .coef_wr_stb(coef_wr_stb), .coef_filter(coef_filter),
    .coef_tap(coef_tap), .coef_data(coef_data), .sample_valid(sample_valid),
    .sample_in(sample_in), .sat_clr(sat_clr), .busy(busy), .out_valid(out_valid),
    .out_filter(out_filter), .out_data(out_data), .overrun(overrun), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct { int filt; int data; } exp_t;
  exp_t   sb[$];
  exp_t   mon_e;
  int     compared = 0;
  int     mismatched = 0;
  longint mx[TAPS];
  longint mc[FILTERS][TAPS];
  longint last_f2 = 0;

  task automatic check(input string tag, input longint obs, input longint expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint sat24(input longint v);
    if (v > 64'sd8388607)  return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
  endfunction

  // Reference model: shift the delay line and queue one result per filter.
  task automatic model_sample(input int s);
    longint acc;
    exp_t   e;
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = s;
    for (int f = 0; f < FILTERS; f++) begin
      acc = 0;
      for (int t = 0; t < TAPS; t++) acc += mx[t] * mc[f][t];
      e.filt = f;
      e.data = int'(sat24(acc >>> (COEF_W - 1)));
      sb.push_back(e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) mx[i] = 0;
    for (int f = 0; f < FILTERS; f++)
      for (int t = 0; t < TAPS; t++) mc[f][t] = 0;
  endtask

  // Scoreboard consumer: every out_valid pops one expected result.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out_filter", longint'(out_filter), longint'(mon_e.filt));
        check("out_data", longint'($signed(out_data)), longint'(mon_e.data));
        if (out_filter == 2'd2) last_f2 = longint'($signed(out_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int f, input int t, input logic [15:0] d);
    coef_filter = 2'(f);
    coef_tap    = 3'(t);
    coef_data   = d;
    coef_wr_stb = 1'b1;
    tick();
    coef_wr_stb = 1'b0;
    mc[f][t] = longint'($signed(d));
  endtask

  // Returns in cycle 1 of the new computation.
  task automatic start_sample(input int s);
    model_sample(s);
    sample_in    = s[23:0];
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 1, 0);
    check("sb_drained", longint'(sb.size()), 0);
  endtask

  initial begin
    reset_n = 1'b0; coef_wr_stb = 1'b0; coef_filter = '0; coef_tap = '0;
    coef_data = '0; sample_valid = 1'b0; sample_in = '0; sat_clr = 1'b0;
    model_clear();

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_filter", out_filter, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sat_flag", sat_flag, 0);
    reset_n = 1'b1;
    tick();

    // Impulse with cleared coefficients: all results zero
    start_sample(32768);
    wait_idle();

    // Gain 0.5 on filter 0, with cycle-exact busy/out_valid timing
    write_coef(0, 0, 16'h4000);
    start_sample(1000);
    for (int k = 1; k <= 37; k++) begin
      check($sformatf("gain_busy_c%0d", k), busy, (k <= 36) ? 1 : 0);
      check($sformatf("gain_valid_c%0d", k), out_valid, (k % 9 == 0 && k <= 36) ? 1 : 0);
      tick();
    end
    check("gain_sb_drained", longint'(sb.size()), 0);

    // Impulse response of filter 1
    for (int t = 0; t < TAPS; t++) write_coef(1, t, 16'(t + 1));
    start_sample(32768);
    wait_idle();
    for (int i = 0; i < 7; i++) begin
      start_sample(0);
      wait_idle();
    end

    // Saturation on filter 2
    for (int t = 0; t < TAPS; t++) write_coef(2, t, 16'h7FFF);
    for (int i = 0; i < 8; i++) begin
      start_sample(8388607);
      wait_idle();
    end
    check("sat_pos_f2", last_f2, 8388607);
    check("sat_flag_set", sat_flag, 1);
    for (int i = 0; i < 8; i++) begin
      start_sample(-8388608);
      wait_idle();
    end
    check("sat_neg_f2", last_f2, -8388608);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check("sat_flag_clr", sat_flag, 0);

    // Overrun: second strobe at cycle 5 is dropped, pulse at cycle 6
    start_sample(12345);
    repeat (4) tick();
    sample_in    = 24'd999;
    sample_valid = 1'b1;
    check("ovr_before", overrun, 0);
    tick();
    sample_valid = 1'b0;
    check("ovr_pulse", overrun, 1);
    tick();
    check("ovr_after", overrun, 0);
    wait_idle();
    start_sample(0);
    wait_idle();

    // Write hazard: c[0][3] rewritten in the cycle it is read (cycle 4)
    write_coef(0, 3, 16'h1000);
    start_sample(500);
    repeat (3) tick();
    coef_filter = 2'd0; coef_tap = 3'd3; coef_data = 16'h3000; coef_wr_stb = 1'b1;
    tick();
    coef_wr_stb = 1'b0;
    mc[0][3] = 64'sh3000;
    wait_idle();
    start_sample(-700);
    wait_idle();

    // Reset mid-computation at cycle 12
    start_sample(4242);
    repeat (11) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_pending", longint'(sb.size()), 3);
    sb.delete();
    model_clear();
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid || busy) check("midrst_quiet", {out_valid, busy}, 0);
    end
    check("midrst_sat_flag", sat_flag, 0);

    // Impulse after reset: coefficients cleared
    start_sample(32768);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
